// File: rtl/rob_queue_mp.sv
// Multi-port reorder-buffer queue: in-order allocate at tail, out-of-order writeback, in-order retire of up to COMMIT_W entries per cycle.
// Latency: issue/writeback land at the next rising edge; commit outputs are combinational from registered state and retire at the edge of the request.
// Backpressure: issue_ready = ~full from the registered count (a same-cycle commit does not free a slot for issue); issue while full is ignored.
//
// Ports:
//   clk, rst (sync, active-low), flush (sync clear)
//   issue/issue_data/issue_ready/issue_idx  : dispatch-side allocation at the tail
//   wb_valid/wb_idx/wb_data                 : NUM_WB writeback ports, packed per port
//   commit_valid/commit_data/commit_idx     : COMMIT_W retire slots starting at head
//   commit_req                              : consumer retire request per slot
//   head_idx/count/empty/full               : queue status
module rob_queue_mp #(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 5,
  parameter int NUM_WB   = 7,
  parameter int COMMIT_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         issue,
  input  logic [DATA_W-1:0]            issue_data,
  output logic                         issue_ready,
  output logic [IDX_W-1:0]             issue_idx,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]      wb_idx,
  input  logic [NUM_WB*DATA_W-1:0]     wb_data,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*DATA_W-1:0]   commit_data,
  output logic [COMMIT_W*IDX_W-1:0]    commit_idx,
  input  logic [COMMIT_W-1:0]          commit_req,
  output logic [IDX_W-1:0]             head_idx,
  output logic [IDX_W:0]               count,
  output logic                         empty,
  output logic                         full
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              issue_acc;
  logic [CNT_W-1:0]  retire_n;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign issue_ready = ~full;
  assign issue_idx   = tail_q;
  assign head_idx    = head_q;
  assign count       = count_q;
  assign issue_acc   = issue & ~full;

  // Slot k is offered only if every earlier slot is offered too, and never
  // past the occupancy, so a retire can't run into the tail.
  always_comb begin
    logic [IDX_W-1:0] slot_idx;
    logic             run;
    commit_valid = '0;
    commit_data  = '0;
    commit_idx   = '0;
    run          = 1'b1;
    slot_idx     = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx = head_q + IDX_W'(k);
      commit_idx[k*IDX_W +: IDX_W]    = slot_idx;
      commit_data[k*DATA_W +: DATA_W] = data_q[slot_idx];
      run = run & (CNT_W'(k) < count_q) & valid_q[slot_idx] & done_q[slot_idx];
      commit_valid[k] = run;
    end
  end

  // Retire count is the run of accepted slots starting at slot 0; a request
  // on a later slot after a gap is ignored.
  always_comb begin
    retire_n = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (commit_req[k] && commit_valid[k] && (retire_n == CNT_W'(k))) begin
        retire_n = retire_n + 1'b1;
      end
    end
  end

  // Control state. Assignment order matters: later ports override earlier
  // ones, and the retire clear overrides a writeback to a retiring entry.
  // The tail entry is always invalid when an issue is accepted, so a
  // writeback aimed at it is already filtered by valid_q.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && valid_q[wb_idx[p*IDX_W +: IDX_W]]) begin
          done_q[wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (CNT_W'(k) < retire_n) begin
          valid_q[head_q + IDX_W'(k)] <= 1'b0;
          done_q[head_q + IDX_W'(k)]  <= 1'b0;
        end
      end
      if (issue_acc) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      head_q  <= head_q + retire_n[IDX_W-1:0];
      count_q <= count_q + CNT_W'(issue_acc) - retire_n;
    end
  end

  // Payload array carries no reset; its contents only matter where valid_q
  // is set, and valid_q gates every writeback.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p] && valid_q[wb_idx[p*IDX_W +: IDX_W]]) begin
        data_q[wb_idx[p*IDX_W +: IDX_W]] <= wb_data[p*DATA_W +: DATA_W];
      end
    end
    if (issue_acc) begin
      data_q[tail_q] <= issue_data;
    end
  end

endmodule
